// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler for a shared 1:4 demultiplexer datapath.
// The scheduler grants one enabled channel at a time and moves bursts of up to
// BURST words from a single valid/ready input stream to that channel. A one-cycle
// arbitration bubble separates grants. The select output stays stable for the
// whole burst.
module demux_rr_scheduler #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned BURST = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ch_en,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [1:0]       sel,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StArb, StXfer} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BURST - 1);

   state_e           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0] arb_pick;
   logic [1:0] cand;
   logic       arb_found;
   logic       grant_en;
   logic       xfer_fire;

   assign grant_en  = ch_en[sel_q];
   assign xfer_fire = in_valid & in_ready;

   // Round-robin search: the first enabled channel after the last one served.
   always_comb begin
      arb_pick  = last_q;
      arb_found = 1'b0;
      cand      = last_q;
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!arb_found && ch_en[cand]) begin
            arb_pick  = cand;
            arb_found = 1'b1;
         end
      end
   end

   // State register. The reset value of last makes the first grant search start at ch0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= 2'b00;
         last_q  <= 2'b11;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: choose the grant in ARB, then count words in XFER.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (|ch_en) state_d = StArb;
         end
         StArb: begin
            cnt_d = '0;
            if (ch_en == 4'b0000) begin
               state_d = StIdle;
            end else begin
               sel_d   = arb_pick;
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (!grant_en) begin
               // The granted channel was disabled, so its grant ends at once.
               last_d  = sel_q;
               state_d = StArb;
            end else if (xfer_fire) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LastCnt) begin
                  last_d  = sel_q;
                  state_d = StArb;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode. The handshake is combinational in XFER. It is suppressed
   // while rst is high so that the word in a reset cycle is not accepted.
   always_comb begin
      out_valid = 4'b0000;
      in_ready  = 1'b0;
      if (state_q == StXfer && !rst) begin
         out_valid[sel_q] = in_valid & grant_en;
         in_ready         = out_ready[sel_q] & grant_en;
      end
   end

   assign out_data = in_data;
   assign sel      = sel_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed testbench for demux_rr_scheduler, with hand-computed expected values.
module tb_demux_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] ch_en;
   logic [7:0] out_data;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [1:0] sel;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   demux_rr_scheduler #(
      .WIDTH(8),
      .BURST(4),
      .CNT_W(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ch_en    (ch_en),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sel      (sel),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // The scheduler is in IDLE this cycle.
   task automatic expect_idle(input string tag);
      #1;
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
      check({tag, "_iready"}, 32'(in_ready), 32'd0);
      tick();
   endtask

   // The scheduler is in the ARB bubble this cycle.
   task automatic expect_bubble(input string tag);
      #1;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
      check({tag, "_iready"}, 32'(in_ready), 32'd0);
      tick();
   endtask

   // The scheduler transfers n words to channel ch, one word per cycle.
   task automatic expect_words(input string tag, input int ch, input int n);
      logic [3:0] oh;
      oh = 4'b0001 << ch;
      for (int k = 0; k < n; k++) begin
         in_data = 8'(ch * 16 + k + 1);
         #1;
         check({tag, "_sel"}, 32'(sel), 32'(ch));
         check({tag, "_ovalid"}, 32'(out_valid), 32'(oh));
         check({tag, "_iready"}, 32'(in_ready), 32'd1);
         check({tag, "_odata"}, 32'(out_data), 32'(ch * 16 + k + 1));
         tick();
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b1;
      ch_en     = 4'b1111;
      out_ready = 4'b1111;

      // Test 1: all channels enabled, so grants go in order 0,1,2,3,0.
      do_reset();
      #1;
      check("t1_reset_sel", 32'(sel), 32'd0);
      expect_idle("t1_idle");
      expect_bubble("t1_arb0");
      expect_words("t1_ch0", 0, 4);
      expect_bubble("t1_arb1");
      expect_words("t1_ch1", 1, 4);
      expect_bubble("t1_arb2");
      expect_words("t1_ch2", 2, 4);
      expect_bubble("t1_arb3");
      expect_words("t1_ch3", 3, 4);
      expect_bubble("t1_arb4");
      expect_words("t1_ch0b", 0, 4);

      // Test 2: ch_en=1010, so grants alternate between ch1 and ch3.
      ch_en = 4'b1010;
      do_reset();
      expect_idle("t2_idle");
      expect_bubble("t2_arb0");
      expect_words("t2_ch1", 1, 4);
      expect_bubble("t2_arb1");
      expect_words("t2_ch3", 3, 4);
      expect_bubble("t2_arb2");
      expect_words("t2_ch1b", 1, 4);

      // Test 3: ch2 stalls mid-burst, and the grant is held until it resumes.
      ch_en = 4'b0100;
      do_reset();
      expect_idle("t3_idle");
      expect_bubble("t3_arb0");
      expect_words("t3_ch2a", 2, 2);
      out_ready = 4'b1011;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t3_stall_iready", 32'(in_ready), 32'd0);
         check("t3_stall_sel", 32'(sel), 32'd2);
         check("t3_stall_ovalid", 32'(out_valid), 32'b0100);
         tick();
      end
      out_ready = 4'b1111;
      // The count did not move during the stall, so exactly two more words finish the burst.
      expect_words("t3_ch2b", 2, 2);
      expect_bubble("t3_arb1");
      expect_words("t3_ch2c", 2, 1);

      // Test 4: ch1 is disabled after 2 words, and the next grant goes to ch2.
      ch_en = 4'b0111;
      do_reset();
      expect_idle("t4_idle");
      expect_bubble("t4_arb0");
      expect_words("t4_ch0", 0, 4);
      expect_bubble("t4_arb1");
      expect_words("t4_ch1", 1, 2);
      ch_en = 4'b0101;
      #1;
      check("t4_drop_ovalid", 32'(out_valid), 32'd0);
      check("t4_drop_iready", 32'(in_ready), 32'd0);
      tick();
      expect_bubble("t4_arb2");
      expect_words("t4_ch2", 2, 4);

      // Test 5: reset is asserted mid-burst, and the next grant restarts at ch0.
      ch_en = 4'b1111;
      do_reset();
      expect_idle("t5_idle");
      expect_bubble("t5_arb0");
      expect_words("t5_ch0", 0, 2);
      rst = 1'b1;
      #1;
      check("t5_rstcyc_iready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("t5_post_sel", 32'(sel), 32'd0);
      expect_idle("t5_post");
      expect_bubble("t5_arb1");
      expect_words("t5_ch0b", 0, 1);

      // Test 6: with no channel enabled, the scheduler stays idle.
      ch_en = 4'b0000;
      do_reset();
      for (int i = 0; i < 8; i++) expect_idle("t6_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
